// File: rtl/sram_cmd_pipe.sv
// Elastic ZBT SRAM command pipeline with valid/ready back-pressure and flush,
// plus read-return tracking that re-times sram_rdata to the SRAM read latency.
module sram_cmd_pipe #(
    parameter int ASIZE  = 18,
    parameter int DSIZE  = 36,
    parameter int BWSIZE = 4,
    parameter int STAGES = 2,
    parameter int RD_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ASIZE-1:0]  in_addr,
    input  logic [DSIZE-1:0]  in_wdata,
    input  logic              in_rd_wr_n,
    input  logic              in_adv_ld_n,
    input  logic [BWSIZE-1:0] in_dm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ASIZE-1:0]  out_addr,
    output logic [DSIZE-1:0]  out_wdata,
    output logic              out_rd_wr_n,
    output logic              out_adv_ld_n,
    output logic [BWSIZE-1:0] out_dm,
    input  logic [DSIZE-1:0]  sram_rdata,
    output logic [DSIZE-1:0]  rd_data,
    output logic              rd_data_valid,
    output logic [3:0]        occupancy
);

    localparam int PW = ASIZE + DSIZE + 2 + BWSIZE;
    // Idle payload reads as a burst-advance read so the SRAM side sees a benign command.
    localparam logic [PW-1:0] PAY_RST = {{(ASIZE + DSIZE){1'b0}}, 2'b11, {BWSIZE{1'b0}}};

    if (STAGES < 1 || STAGES > 8) begin : g_bad_stages
        $error("sram_cmd_pipe: STAGES must be 1..8");
    end
    if (RD_LAT < 1 || RD_LAT > 8) begin : g_bad_rd_lat
        $error("sram_cmd_pipe: RD_LAT must be 1..8");
    end

    logic [STAGES-1:0] r_valid;
    logic [PW-1:0]     r_pay [STAGES];
    logic [RD_LAT-1:0] r_tag;
    logic              r_last_is_read;
    logic              r_rd_data_valid;
    logic [DSIZE-1:0]  r_rd_data;
    logic [3:0]        r_occ;

    logic [STAGES-1:0] w_adv;
    logic [STAGES-1:0] w_load;
    logic [STAGES-1:0] w_valid_nxt;
    logic [3:0]        w_occ_nxt;
    logic [PW-1:0]     w_in_pay;
    logic              w_xfer;
    logic              w_fire;
    logic              w_read_fire;

    // Ready chain walks from the head back to the input; a stage advances
    // when it holds a command and its downstream neighbour can take it.
    always_comb begin
        logic w_dn_ready;
        w_adv      = '0;
        w_dn_ready = out_ready;
        for (int i = STAGES - 1; i >= 0; i--) begin
            w_adv[i]   = r_valid[i] & w_dn_ready & ~flush;
            w_dn_ready = ~r_valid[i] | (r_valid[i] & w_dn_ready & ~flush);
        end
    end

    assign in_ready  = (~r_valid[0] | w_adv[0]) & ~flush;
    assign w_xfer    = in_valid & in_ready;
    assign w_load    = (w_adv << 1) | STAGES'(w_xfer);
    assign w_in_pay  = {in_addr, in_wdata, in_rd_wr_n, in_adv_ld_n, in_dm};

    assign out_valid = r_valid[STAGES-1] & ~flush;
    assign {out_addr, out_wdata, out_rd_wr_n, out_adv_ld_n, out_dm} = r_pay[STAGES-1];

    assign w_fire      = out_valid & out_ready;
    // A burst advance inherits the direction of the most recent load.
    assign w_read_fire = w_fire & (out_adv_ld_n ? r_last_is_read : out_rd_wr_n);

    always_comb begin
        w_valid_nxt = '0;
        if (!flush) begin
            w_valid_nxt = w_load | (r_valid & ~w_adv);
        end
    end

    always_comb begin
        w_occ_nxt = '0;
        for (int i = 0; i < STAGES; i++) begin
            w_occ_nxt = w_occ_nxt + {3'b000, w_valid_nxt[i]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < STAGES; i++) begin
                r_pay[i] <= PAY_RST;
            end
        end else begin
            if (w_load[0]) begin
                r_pay[0] <= w_in_pay;
            end
            for (int i = 1; i < STAGES; i++) begin
                if (w_load[i]) begin
                    r_pay[i] <= r_pay[i-1];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= '0;
            r_occ   <= '0;
        end else begin
            r_valid <= w_valid_nxt;
            r_occ   <= w_occ_nxt;
        end
    end

    // Read tracking deliberately ignores flush so already-issued reads still return.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tag           <= '0;
            r_last_is_read  <= 1'b0;
            r_rd_data_valid <= 1'b0;
            r_rd_data       <= '0;
        end else begin
            r_tag[0] <= w_read_fire;
            for (int i = 1; i < RD_LAT; i++) begin
                r_tag[i] <= r_tag[i-1];
            end
            if (w_fire && !out_adv_ld_n) begin
                r_last_is_read <= out_rd_wr_n;
            end
            r_rd_data_valid <= r_tag[RD_LAT-1];
            if (r_tag[RD_LAT-1]) begin
                r_rd_data <= sram_rdata;
            end
        end
    end

    assign rd_data       = r_rd_data;
    assign rd_data_valid = r_rd_data_valid;
    assign occupancy     = r_occ;

endmodule
